// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the Reg/Imm core sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int PC_STEP = 4;

  // Only register/register and register/immediate ALU ops are executable.
  function automatic logic is_legal_opc(input logic [6:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Instruction-memory fetch bus: req/addr out, valid/rdata back.
// Latency: memory may take any number of cycles to assert imem_valid.
// Backpressure: requester holds imem_req/imem_addr until imem_valid.
interface core_seq_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/core_fetch_timer.sv
// Loadable/clearable up-counter that flags the cycle it would reach LIMIT.
// Latency: expire is combinational from the count and inc; count updates next edge.
// Backpressure: none; ports: clk, rst_n, load/load_val, clr, inc, expire.
module core_fetch_timer #(
  parameter  int LIMIT = 255,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  input  logic         inc,
  output logic         expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Asserted on the increment that takes the count to LIMIT, so the owner
  // can act on the same edge the limit is reached.
  assign expire = inc && (cnt_q == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with PC, IR, retire count, sticky halt.
// Latency: 4 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: stalls in FETCH until imem_valid; halts with timeout after TIMEOUT_CYCLES waits.
// Ports: ip_clk/ip_rst_n, ip_run enable, imem fetch bus, decoder/ALU/RF strobes, pc/count/halt/err status.
module core_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int                  TIMEOUT_CYCLES = 255
) (
  input  logic                ip_clk,
  input  logic                ip_rst_n,
  input  logic                ip_run,
  core_seq_ctrl_if.master     imem,
  output logic [31:0]         op_instr,
  output logic                op_instr_valid,
  output logic                op_alu_en,
  output logic                op_rf_we,
  output logic [PC_WIDTH-1:0] op_pc,
  output logic [31:0]         op_retired_cnt,
  output logic                op_halted,
  output logic [1:0]          op_err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         ir_q;
  logic [31:0]         retired_q;
  logic [1:0]          err_q;

  logic in_fetch;
  logic fetch_ok;
  logic fetch_wait;
  logic tmo_expire;
  logic opc_legal;

  assign in_fetch   = (state_q == ST_FETCH);
  assign fetch_ok   = in_fetch && imem.imem_valid;
  assign fetch_wait = in_fetch && !imem.imem_valid;
  assign opc_legal  = is_legal_opc(ir_q[6:0]);

  core_fetch_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk      (ip_clk),
    .rst_n    (ip_rst_n),
    .load     (1'b0),
    .load_val ({TW{1'b0}}),
    .clr      (fetch_ok),
    .inc      (fetch_wait),
    .expire   (tmo_expire)
  );

  // State register
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In FETCH a valid beats an expiring timer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (ip_run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_valid)  state_d = ST_DECODE;
        else if (tmo_expire)  state_d = ST_HALT;
      end
      ST_DECODE:    state_d = opc_legal ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ip_run ? ST_FETCH : ST_IDLE;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops the fetch request at once.
  always_comb begin
    imem.imem_req  = 1'b0;
    op_instr_valid = 1'b0;
    op_alu_en      = 1'b0;
    op_rf_we       = 1'b0;
    op_halted      = 1'b0;
    case (state_q)
      ST_FETCH:     imem.imem_req = 1'b1;
      ST_DECODE:    op_instr_valid = 1'b1;
      ST_EXECUTE: begin
        op_instr_valid = 1'b1;
        op_alu_en      = 1'b1;
      end
      ST_WRITEBACK: begin
        op_instr_valid = 1'b1;
        op_rf_we       = 1'b1;
      end
      ST_HALT:      op_halted = 1'b1;
      default:      ;
    endcase
  end

  // IR only loads on a successful fetch, so it holds through DECODE..WRITEBACK
  // and across IDLE/HALT until the next fetch completes.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      ir_q <= '0;
    end else if (fetch_ok) begin
      ir_q <= imem.imem_rdata;
    end
  end

  // PC and retire count advance together on WRITEBACK exit; both wrap naturally.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else if (state_q == ST_WRITEBACK) begin
      pc_q      <= pc_q + PC_WIDTH'(PC_STEP);
      retired_q <= retired_q + 32'd1;
    end
  end

  // Error code is written only on the edge that enters HALT, then held.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      err_q <= ERR_NONE;
    end else if ((state_q == ST_DECODE) && !opc_legal) begin
      err_q <= ERR_ILLEGAL;
    end else if (fetch_wait && tmo_expire) begin
      err_q <= ERR_TIMEOUT;
    end
  end

  assign imem.imem_addr = pc_q;
  assign op_pc          = pc_q;
  assign op_instr       = ir_q;
  assign op_retired_cnt = retired_q;
  assign op_err_code    = err_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: two instances (reset PC 0 and 0xFFFF_FFFC) share one stimulus.
// Expected outputs come from a per-instruction timeline model (wait cycles, opcode, run).
// Ports: all DUT ports connected; clock generated locally.
module tb_core_seq_ctrl;

  localparam int          TMO   = 4;
  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        run       = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  core_seq_ctrl_if #(.PC_WIDTH(32)) imem_a ();
  core_seq_ctrl_if #(.PC_WIDTH(32)) imem_b ();

  assign imem_a.imem_valid = mem_valid;
  assign imem_a.imem_rdata = mem_rdata;
  assign imem_b.imem_valid = mem_valid;
  assign imem_b.imem_rdata = mem_rdata;

  logic [31:0] a_instr, b_instr, a_pc, b_pc, a_cnt, b_cnt;
  logic        a_iv, b_iv, a_alu, b_alu, a_we, b_we, a_halt, b_halt;
  logic [1:0]  a_err, b_err;

  core_seq_ctrl #(.PC_WIDTH(32), .RESET_PC(RST_A), .TIMEOUT_CYCLES(TMO)) u_dut_a (
    .ip_clk         (clk),
    .ip_rst_n       (rst_n),
    .ip_run         (run),
    .imem           (imem_a),
    .op_instr       (a_instr),
    .op_instr_valid (a_iv),
    .op_alu_en      (a_alu),
    .op_rf_we       (a_we),
    .op_pc          (a_pc),
    .op_retired_cnt (a_cnt),
    .op_halted      (a_halt),
    .op_err_code    (a_err)
  );

  core_seq_ctrl #(.PC_WIDTH(32), .RESET_PC(RST_B), .TIMEOUT_CYCLES(TMO)) u_dut_b (
    .ip_clk         (clk),
    .ip_rst_n       (rst_n),
    .ip_run         (run),
    .imem           (imem_b),
    .op_instr       (b_instr),
    .op_instr_valid (b_iv),
    .op_alu_en      (b_alu),
    .op_rf_we       (b_we),
    .op_pc          (b_pc),
    .op_retired_cnt (b_cnt),
    .op_halted      (b_halt),
    .op_err_code    (b_err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_ir  = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Architectural PC: reset value plus one step per retired instruction, mod 2^32.
  function automatic logic [31:0] pc_model(input logic [31:0] base);
    return base + 32'(exp_cnt) * 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_outs(input string tag, input logic req, input logic iv,
                             input logic alu, input logic we, input logic hlt,
                             input logic [1:0] err);
    check({tag, "/req"},   64'(imem_a.imem_req), 64'(req));
    check({tag, "/addr"},  64'(imem_a.imem_addr), 64'(pc_model(RST_A)));
    check({tag, "/iv"},    64'(a_iv), 64'(iv));
    check({tag, "/alu"},   64'(a_alu), 64'(alu));
    check({tag, "/we"},    64'(a_we), 64'(we));
    check({tag, "/halt"},  64'(a_halt), 64'(hlt));
    check({tag, "/err"},   64'(a_err), 64'(err));
    check({tag, "/pc"},    64'(a_pc), 64'(pc_model(RST_A)));
    check({tag, "/cnt"},   64'(a_cnt), 64'(exp_cnt));
    check({tag, "/instr"}, 64'(a_instr), 64'(exp_ir));
    check({tag, "/b_req"}, 64'(imem_b.imem_req), 64'(req));
    check({tag, "/b_pc"},  64'(b_pc), 64'(pc_model(RST_B)));
    check({tag, "/b_addr"},64'(imem_b.imem_addr), 64'(pc_model(RST_B)));
    check({tag, "/b_we"},  64'(b_we), 64'(we));
    check({tag, "/b_halt"},64'(b_halt), 64'(hlt));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    mem_valid = 1'b0;
    exp_cnt   = 0;
    exp_ir    = '0;
    #3;
    expect_outs("in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  // From IDLE: raise run, one edge later the block is fetching.
  task automatic start();
    run = 1'b1;
    tick();
  endtask

  task automatic hold_halt(input logic [1:0] err);
    expect_outs("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err);
    for (int i = 0; i < 4; i++) begin
      run       = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      tick();
      expect_outs("halt_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, err);
    end
  endtask

  // Entered with the DUT in FETCH. Memory answers after wait_n idle cycles
  // (never, if wait_n >= TMO). On normal completion the DUT is back in FETCH.
  task automatic run_instr(input logic [31:0] word, input int wait_n,
                           input bit drop_run, output bit stopped);
    bit got = 1'b0;
    bit legal;
    stopped = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      expect_outs("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      if (k == wait_n) begin
        mem_valid = 1'b1;
        mem_rdata = word;
        tick();
        got = 1'b1;
        break;
      end
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      tick();
    end
    if (!got) begin
      hold_halt(2'b10);
      stopped = 1'b1;
      return;
    end
    exp_ir    = word;
    legal     = (word[6:0] == 7'b0110011) || (word[6:0] == 7'b0010011);
    mem_valid = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    expect_outs("decode", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    if (!drop_run) run = 1'($urandom_range(0, 1));
    tick();
    if (!legal) begin
      hold_halt(2'b01);
      stopped = 1'b1;
      return;
    end
    expect_outs("exec", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    run       = drop_run ? 1'b0 : 1'($urandom_range(0, 1));
    mem_valid = 1'($urandom_range(0, 1));
    tick();
    expect_outs("wb", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    run = !drop_run;
    tick();
    exp_cnt++;
    if (drop_run) begin
      repeat ($urandom_range(1, 3)) begin
        expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        mem_valid = 1'($urandom_range(0, 1));
        tick();
      end
      expect_outs("idle_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      start();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit          st;
    logic [31:0] r;
    logic [31:0] w;
    int          wn;

    @(negedge clk);
    do_reset();

    // Two back-to-back instructions, second with a 3-cycle memory wait,
    // then run drops during EXECUTE of the second.
    start();
    run_instr(32'h0020_8033, 0, 1'b0, st);
    run_instr(32'h0050_0093, 3, 1'b1, st);

    // Branch opcode is illegal.
    run_instr(32'h0000_0063, 0, 1'b0, st);

    // Memory never answers: timeout.
    do_reset();
    start();
    run_instr(32'h0020_8033, TMO, 1'b0, st);

    // Valid arriving on the last permitted fetch cycle wins.
    do_reset();
    start();
    run_instr(32'h0020_8033, TMO - 1, 1'b0, st);

    st = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (st) begin
        do_reset();
        start();
      end
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       w = r;
        1, 2, 3: w = {r[31:7], 7'b0110011};
        default: w = {r[31:7], 7'b0010011};
      endcase
      wn = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(w, wn, ($urandom_range(0, 3) == 0), st);
    end

    // Async reset in the middle of FETCH.
    if (st) begin
      do_reset();
      start();
    end
    expect_outs("pre_arst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    #2;
    rst_n   = 1'b0;
    exp_cnt = 0;
    exp_ir  = '0;
    #1;
    check("arst/req",   64'(imem_a.imem_req), 64'(0));
    check("arst/b_req", 64'(imem_b.imem_req), 64'(0));
    check("arst/pc",    64'(a_pc), 64'(RST_A));
    check("arst/b_pc",  64'(b_pc), 64'(RST_B));
    check("arst/cnt",   64'(a_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the Reg/Imm core.
- Fetches each instruction from instruction memory through a req/valid handshake and holds it in an instruction register.
- Presents the held instruction, qualified by a valid, to the decoder.
- Steps through decode, execute and writeback, gating the ALU enable and register-file write.
- Owns the PC, a retired-instruction counter, and sticky halt/error reporting (illegal opcode, fetch timeout).

Parameters:
PC_WIDTH, 32, width of PC and imem address
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT_CYCLES, 255, FETCH cycles without ip_imem_valid before a timeout halt (must be ≥1)

Ports:
ip_clk  input  1  clock, rising edge
ip_rst_n  input  1  asynchronous active-low reset
ip_run  input  1  enable; sampled in IDLE and at WRITEBACK exit
op_imem_req  output  1  fetch request
op_imem_addr  output  PC_WIDTH  fetch address (equals PC)
ip_imem_valid  input  1  fetch data valid
ip_imem_rdata  input  32  fetched instruction
op_instr  output  32  instruction register, to decoder
op_instr_valid  output  1  decoder valid qualifier
op_alu_en  output  1  ALU operate strobe
op_rf_we  output  1  register-file write strobe
op_pc  output  PC_WIDTH  current PC
op_retired_cnt  output  32  retired-instruction count
op_halted  output  1  sticky halt flag
op_err_code  output  2  00 none, 01 illegal opcode, 10 fetch timeout

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, PC=RESET_PC.
  - IR, retired count, timeout counter, err_code all 0.
  - All strobes 0, op_halted=0.
  - Reset mid-operation drops op_imem_req immediately.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - All strobes 0.
  - ip_run=1 → FETCH next cycle.
- FETCH:
  - op_imem_req=1, op_imem_addr=PC.
  - On a rising edge with ip_imem_valid=1: IR←ip_imem_rdata, timeout counter cleared, → DECODE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES → HALT with err=10.
  - If valid arrives in the same cycle the counter would reach the limit, valid wins.
  - ip_imem_valid is ignored in every other state.
- DECODE:
  - op_instr_valid=1.
  - IR[6:0]=7'b0110011 (R-type) or 7'b0010011 (I-type) → EXECUTE.
  - Any other opcode → HALT with err=01. PC and retired count are not updated.
- EXECUTE: op_instr_valid=1, op_alu_en=1 for exactly one cycle → WRITEBACK.
- WRITEBACK:
  - op_instr_valid=1, op_rf_we=1 for exactly one cycle.
  - At exit: PC←PC+4 (wraps modulo 2^PC_WIDTH), retired_cnt←retired_cnt+1 (wraps at 2^32).
  - Next state: FETCH if ip_run=1, else IDLE.
- Deasserting ip_run mid-instruction does not abort; the current instruction completes, then the block idles.
- HALT:
  - Sticky until reset.
  - op_halted=1, op_err_code held.
  - All strobes 0, op_imem_req=0. PC and IR frozen.
  - ip_run is ignored.
- Latency: one instruction takes 4 cycles with zero-wait memory (FETCH, DECODE, EXECUTE, WRITEBACK); each memory wait cycle adds 1.
- op_instr holds its value from the DECODE entry until the next successful fetch.

Decomposition:
- Package core_ctrl_pkg holds:
  - state enumeration
  - OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011
  - ERR_NONE/ERR_ILLEGAL/ERR_TIMEOUT codes
  - PC_STEP=4
- One sub-module, core_fetch_timer: loadable/clearable counter of width clog2(TIMEOUT_CYCLES+1), with an expire output. It is instantiated once for the FETCH timeout.
- The FSM, PC, IR and retired counter stay in core_seq_ctrl.

Test Plan:
1. Reset, ip_run=1, zero-wait memory returning 0x00208033 (add) then 0x00500093 (addi):
   - op_rf_we pulses in cycles 4 and 8.
   - op_pc goes 0→4→8.
   - op_retired_cnt=2 after cycle 8.
   - op_imem_addr=0 then 4.
2. Memory delays valid by 3 cycles on the second fetch → FETCH lasts 4 cycles, total 11 cycles for 2 instructions, no error.
3. Fetch returns 0x00000063 (branch opcode) → HALT one cycle after DECODE:
   - op_err_code=01, op_halted=1.
   - op_pc unchanged, op_rf_we never pulses.
   - Toggling ip_run has no effect.
4. TIMEOUT_CYCLES=4, memory never valid → HALT after 4 FETCH cycles with op_err_code=10, op_imem_req=0 afterwards. A second run with valid arriving on the 4th FETCH cycle completes normally.
5. Drop ip_run during EXECUTE → WRITEBACK still pulses op_rf_we, PC+4, then IDLE with op_imem_req=0.
6. PC_WIDTH=32, RESET_PC=32'hFFFF_FFFC, one instruction retired → PC wraps to 0. Assert ip_rst_n low mid-FETCH → op_imem_req falls without waiting for a clock edge and PC returns to RESET_PC.
